// File: rtl/cam_pkg.sv
// Shared types and constants for the OV5642 camera power sequencer.
package cam_pkg;

  localparam int TMR_W = 24;

  // Defaults assume a 100 MHz clock: 1 ms PWDN, 1 ms RESETB, 20 ms boot.
  localparam int DEF_T_PWDN_CYC = 100000;
  localparam int DEF_T_RST_CYC  = 100000;
  localparam int DEF_T_BOOT_CYC = 2000000;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWDN  = 3'd1,
    S_RST   = 3'd2,
    S_BOOT  = 3'd3,
    S_READY = 3'd4
  } state_t;

  function automatic logic [TMR_W-1:0] tmr_load(input int cyc);
    tmr_load = TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that parks at zero; o_zero flags the final cycle of a state.
module seq_timer
  import cam_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_async_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != {W{1'b0}}) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/cam_pwr_seq.sv
// OV5642 power-up sequencer: PWDN -> RESETB -> boot wait -> ready, with restart.
// Optional macro CAM_PWR_SEQ_XCLK_GATE_EN gates XCLK off until PWDN is released.
module cam_pwr_seq
  import cam_pkg::*;
#(
  parameter int T_PWDN_CYC = DEF_T_PWDN_CYC,
  parameter int T_RST_CYC  = DEF_T_RST_CYC,
  parameter int T_BOOT_CYC = DEF_T_BOOT_CYC
) (
  input  logic i_clk,
  input  logic i_async_rst,
  input  logic i_restart,
  output logic o_cam_pwdn,
  output logic o_cam_resetb,
  output logic o_xclk_en,
  output logic o_cam_ready
);

  localparam logic [TMR_W-1:0] LD_PWDN = tmr_load(T_PWDN_CYC);
  localparam logic [TMR_W-1:0] LD_RST  = tmr_load(T_RST_CYC);
  localparam logic [TMR_W-1:0] LD_BOOT = tmr_load(T_BOOT_CYC);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic [TMR_W-1:0] w_load_val;
  logic             w_zero;
  logic             w_pwdn;
  logic             w_resetb;
  logic             w_ready;
  logic             w_xclk;

  seq_timer #(.W(TMR_W)) u_timer (
    .i_clk       (i_clk),
    .i_async_rst (i_async_rst),
    .i_load      (w_load),
    .i_value     (w_load_val),
    .o_zero      (w_zero)
  );

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  // Restart outranks timer expiry; S_OFF always falls through to S_PWDN.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = {TMR_W{1'b0}};
    if (i_restart && (r_state != S_OFF)) begin
      w_next = S_OFF;
      w_load = 1'b1;
    end else begin
      case (r_state)
        S_OFF: begin
          w_next     = S_PWDN;
          w_load     = 1'b1;
          w_load_val = LD_PWDN;
        end
        S_PWDN: begin
          if (w_zero) begin
            w_next     = S_RST;
            w_load     = 1'b1;
            w_load_val = LD_RST;
          end else begin
            w_next = S_PWDN;
          end
        end
        S_RST: begin
          if (w_zero) begin
            w_next     = S_BOOT;
            w_load     = 1'b1;
            w_load_val = LD_BOOT;
          end else begin
            w_next = S_RST;
          end
        end
        S_BOOT: begin
          if (w_zero) begin
            w_next = S_READY;
          end else begin
            w_next = S_BOOT;
          end
        end
        S_READY: w_next = S_READY;
        default: w_next = S_OFF;
      endcase
    end
  end

  assign w_pwdn   = (w_next == S_OFF) || (w_next == S_PWDN);
  assign w_resetb = (w_next == S_BOOT) || (w_next == S_READY);
  assign w_ready  = (w_next == S_READY);
`ifdef CAM_PWR_SEQ_XCLK_GATE_EN
  assign w_xclk   = ~w_pwdn;
`else
  assign w_xclk   = 1'b1;
`endif

  // Outputs are decoded from the next state so they change on the state edge.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      o_cam_pwdn   <= 1'b1;
      o_cam_resetb <= 1'b0;
      o_cam_ready  <= 1'b0;
      o_xclk_en    <= 1'b0;
    end else begin
      o_cam_pwdn   <= w_pwdn;
      o_cam_resetb <= w_resetb;
      o_cam_ready  <= w_ready;
      o_xclk_en    <= w_xclk;
    end
  end

endmodule

// File: doc/cam_pwr_seq.md
CAM_PWR_SEQ -- requirements
Module: cam_pwr_seq

Interface
REQ-001 The block SHALL have parameter T_PWDN_CYC, default 100000, meaning cycles PWDN is held high after sequence start (legal range 1..2^24-1).
REQ-002 The block SHALL have parameter T_RST_CYC, default 100000, meaning cycles RESETB is held low after PWDN release (legal range 1..2^24-1).
REQ-003 The block SHALL have parameter T_BOOT_CYC, default 2000000, meaning cycles from RESETB release to o_cam_ready (legal range 1..2^24-1).
REQ-004 The block SHALL have port i_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_async_rst, input, 1, reset, asynchronous, active-high (driven by the synchronous-deassert reset stage).
REQ-006 The block SHALL have port i_restart, input, 1, single-cycle request to re-run the full power sequence.
REQ-007 The block SHALL have port o_cam_pwdn, output, 1, OV5642 power-down pin (1 = powered down).
REQ-008 The block SHALL have port o_cam_resetb, output, 1, OV5642 reset pin (0 = in reset).
REQ-009 The block SHALL have port o_xclk_en, output, 1, enable for the camera XCLK generator.
REQ-010 The block SHALL have port o_cam_ready, output, 1, high when the camera may be accessed over SCCB.

Function
REQ-011 The block SHALL implement states S_OFF, S_PWDN, S_RST, S_BOOT and S_READY.
REQ-012 All outputs SHALL be registered flops updated on the same edge as the state change, so they never glitch.
REQ-013 S_OFF: pwdn=1, resetb=0, ready=0; the next edge SHALL always go to S_PWDN.
REQ-014 S_PWDN: pwdn=1, resetb=0, ready=0; the block SHALL stay exactly T_PWDN_CYC cycles, then go to S_RST.
REQ-015 S_RST: pwdn=0, resetb=0, ready=0; the block SHALL stay exactly T_RST_CYC cycles, then go to S_BOOT.
REQ-016 S_BOOT: pwdn=0, resetb=1, ready=0; the block SHALL stay exactly T_BOOT_CYC cycles, then go to S_READY.
REQ-017 S_READY: pwdn=0, resetb=1, ready=1; the block SHALL hold until i_restart or reset.
REQ-018 Timing: counting the first rising edge after reset deassertion as edge 1, pwdn SHALL fall at edge 1+T_PWDN_CYC, resetb SHALL rise at edge 1+T_PWDN_CYC+T_RST_CYC, and ready SHALL rise at edge 1+T_PWDN_CYC+T_RST_CYC+T_BOOT_CYC.
REQ-019 i_restart=1 in any state other than S_OFF SHALL force S_OFF on the next edge and take priority over any timer expiry on that same edge.
REQ-020 i_restart sampled while in S_OFF SHALL be ignored.
REQ-021 The timer SHALL be a single 24-bit down-counter loaded with (T-1) on state entry, advancing when it reaches 0, with no wrap-around.
REQ-022 A parameter of 1 SHALL give a one-cycle state.
REQ-023 Held i_restart SHALL keep the block cycling S_OFF -> S_PWDN -> S_OFF, and ready SHALL never assert.

Reset
REQ-024 While i_async_rst=1, the block SHALL be in S_OFF with timer=0, pwdn=1, resetb=0, ready=0 and o_xclk_en=0, applied immediately without waiting for a clock.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence; after release the sequence SHALL restart from edge 1 per REQ-018.

Configuration
REQ-026 The block SHALL support macro CAM_PWR_SEQ_XCLK_GATE_EN.
REQ-027 With CAM_PWR_SEQ_XCLK_GATE_EN defined, o_xclk_en SHALL be 0 in S_OFF/S_PWDN and 1 in S_RST/S_BOOT/S_READY, rising on the same edge pwdn falls.
REQ-028 Without CAM_PWR_SEQ_XCLK_GATE_EN defined, o_xclk_en SHALL be 0 in reset and 1 from edge 1 onward, including through restarts.

Structure
REQ-029 Package cam_pkg SHALL hold the state enum type, the 24-bit timer width constant, and the default cycle constants for a 100 MHz clock.
REQ-030 The loadable down-counter (load, value, zero flag) SHALL be the sub-module seq_timer; the FSM and output registers SHALL stay in cam_pwr_seq.

Verification (bench parameters T_PWDN_CYC=4, T_RST_CYC=6, T_BOOT_CYC=8; 10 ns clock)
REQ-031 Reset held 3 cycles then released -> pwdn falls at edge 5, resetb rises at edge 11, ready rises at edge 19, and all three are stable thereafter.
REQ-032 i_restart pulsed at edge 25 while in S_READY -> at edge 26 pwdn=1, resetb=0, ready=0; ready rises again at edge 44.
REQ-033 i_restart pulsed on the same edge the S_RST timer expires -> S_OFF is entered, not S_BOOT, and resetb stays 0.
REQ-034 Reset asserted asynchronously mid-cycle during S_BOOT -> outputs reach reset values before the next clock edge; after release, timing repeats per REQ-031.
REQ-035 Build with and without CAM_PWR_SEQ_XCLK_GATE_EN -> o_xclk_en rises at edge 5 and at edge 1 respectively.
REQ-036 Bench parameters all set to 1 -> pwdn falls at edge 2, resetb rises at edge 3, ready rises at edge 4.
